// File: rtl/mdu_pkg.sv
// Shared types and constants for the MDU divide front end.
package mdu_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        HOLD  = 2'b11
    } div_state_e;

    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    // funct3[1] selects the remainder half of the result pair
    function automatic logic is_rem_op(input logic [1:0] t);
        return t[1];
    endfunction

endpackage

// File: rtl/mdu_div_signfix.sv
// Conditional two's-complement negation of an operand pair; used for
// operand magnitudes on the way in and sign correction on the way out.
module mdu_div_signfix #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              a_neg,
    input  logic              b_neg,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out
);

    assign a_out = a_neg ? -a_in : a_in;
    assign b_out = b_neg ? -b_in : b_in;

endmodule

// File: rtl/mdu_div_ctrl.sv
// Divide sequencer: resolves special cases and cache hits locally, otherwise
// runs the unsigned engine and sign-corrects its result.
module mdu_div_ctrl
    import mdu_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        div_in_valid,
    input  logic [1:0]  div_type,
    input  logic        cpu_busy,
    output logic [31:0] div_out,
    output logic        div_out_valid,
    output logic        div_busy,
    output logic        eng_start,
    output logic [31:0] eng_dividend,
    output logic [31:0] eng_divisor,
    input  logic        eng_done,
    input  logic [31:0] eng_quot,
    input  logic [31:0] eng_rem
);

    div_state_e state, state_nxt;

    logic [31:0] op_a, op_b;
    logic [1:0]  op_type;
    logic        op_signed;

    logic        c_vld;
    logic [31:0] c_a, c_b, c_quot, c_rem;
    logic        c_signed;

    logic        req_signed, is_zero, is_ovf, is_hit, accept, finish;
    logic [31:0] mag_a, mag_b, fix_quot, fix_rem;
    logic [31:0] spec_quot, spec_rem;

    assign req_signed = ~div_type[0];
    assign is_zero    = (divisor == 32'd0);
    assign is_ovf     = req_signed && (dividend == INT_MIN) && (divisor == 32'hFFFF_FFFF);
    assign is_hit     = CACHE_EN && c_vld && (c_a == dividend) && (c_b == divisor)
                        && (c_signed == req_signed);
    assign accept     = (state == IDLE) && div_in_valid;
    assign finish     = (state == WAIT) && eng_done;

    mdu_div_signfix #(.DATA_W(32)) u_opfix (
        .a_in  (dividend),
        .b_in  (divisor),
        .a_neg (req_signed & dividend[31]),
        .b_neg (req_signed & divisor[31]),
        .a_out (mag_a),
        .b_out (mag_b)
    );

    // Quotient negates on differing signs; remainder follows the dividend
    mdu_div_signfix #(.DATA_W(32)) u_resfix (
        .a_in  (eng_quot),
        .b_in  (eng_rem),
        .a_neg (op_signed & (op_a[31] ^ op_b[31])),
        .b_neg (op_signed & op_a[31]),
        .a_out (fix_quot),
        .b_out (fix_rem)
    );

    always_comb begin
        spec_quot = c_quot;
        spec_rem  = c_rem;
        if (is_zero) begin
            spec_quot = DIV_ZERO_QUOT;
            spec_rem  = dividend;
        end else if (is_ovf) begin
            spec_quot = INT_MIN;
            spec_rem  = 32'd0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (div_in_valid)
                    state_nxt = (is_zero || is_ovf || is_hit) ? HOLD : ISSUE;
            end
            ISSUE: state_nxt = WAIT;
            WAIT:  if (eng_done) state_nxt = HOLD;
            HOLD:  if (!cpu_busy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Outputs are decoded from the next state so they line up with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_out_valid <= 1'b0;
            div_busy      <= 1'b0;
            eng_start     <= 1'b0;
            eng_dividend  <= 32'd0;
            eng_divisor   <= 32'd0;
            div_out       <= 32'd0;
            c_vld         <= 1'b0;
        end else begin
            div_out_valid <= (state_nxt == HOLD);
            div_busy      <= (state_nxt != IDLE);
            eng_start     <= (state_nxt == ISSUE);
            if (finish) c_vld <= 1'b1;
            if (accept && (state_nxt == ISSUE)) begin
                eng_dividend <= mag_a;
                eng_divisor  <= mag_b;
            end
            if (accept && (state_nxt == HOLD))
                div_out <= is_rem_op(div_type) ? spec_rem : spec_quot;
            else if (finish)
                div_out <= is_rem_op(op_type) ? fix_rem : fix_quot;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_a      <= dividend;
            op_b      <= divisor;
            op_type   <= div_type;
            op_signed <= req_signed;
        end
        if (finish) begin
            c_a      <= op_a;
            c_b      <= op_b;
            c_signed <= op_signed;
            c_quot   <= fix_quot;
            c_rem    <= fix_rem;
        end
    end

endmodule
